// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command master: FSM states, frame geometry and opcodes.
package spi_pkg;

    localparam int         FRAME_BITS = 24;
    localparam int         DATA_BITS  = 8;
    localparam logic [7:0] OP_WR      = 8'h41;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [7:0] opcode,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        return {opcode, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: sclk idles low, toggles every CLK_DIV cycles while enabled,
// and flags the cycle before each rising/falling toggle with a one-cycle strobe.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    assign tick = en_i && (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: sends {opcode, addr, wdata} MSB first and returns the data-phase byte.
// Define SPI_CMD_MASTER_MISO_SYNC_EN to route miso_i through a 2-flop synchronizer.
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int CSN_SETUP = 5,
    parameter int CSN_HOLD  = 5,
    parameter int CSN_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output spi_state_e state_o
);

    // Handshake: a command is taken on a clk edge where cmd_valid && cmd_ready; cmd_ready is
    // high only in IDLE and nothing is queued. rsp_valid is a single-cycle, unacknowledged pulse.

    spi_state_e            state_q, state_d;
    logic [15:0]           tmr_q, tmr_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  rd_sh_q, rd_sh_d;
    logic [DATA_BITS-1:0]  rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  csn_q, csn_d;
    logic                  ready_q, ready_d;

    logic sclk_en, sclk_rise, sclk_fall;
    logic accept, data_phase, sample_en, sample_bit;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (sclk_en),
        .sclk_o(sclk_o),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    assign sclk_en    = (state_q == SHIFT);
    assign accept     = cmd_valid && ready_q;
    // bit_cnt_q counts completed falling edges, so bits 7..0 are the last eight of the frame.
    assign data_phase = (bit_cnt_q >= 5'(FRAME_BITS - DATA_BITS));

`ifdef SPI_CMD_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sync_q <= 2'b00;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso_i};
        end
    end

    // The synchronized copy of the bit seen at the rising toggle is ready by the falling toggle.
    assign sample_en  = sclk_fall && data_phase;
    assign sample_bit = miso_sync_q[1];
`else
    assign sample_en  = sclk_rise && data_phase;
    assign sample_bit = miso_i;
`endif

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rd_sh_d     = rd_sh_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    tmr_d     = '0;
                    bit_cnt_d = '0;
                    rd_sh_d   = '0;
                    shift_d   = pack_frame(cmd_opcode, cmd_addr, cmd_wdata);
                end
            end
            SETUP: begin
                if (tmr_q == 16'(CSN_SETUP)) begin
                    state_d = SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                        state_d = HOLD;
                        tmr_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (tmr_q == 16'(CSN_HOLD - 1)) begin
                    state_d     = GAP;
                    tmr_d       = '0;
                    rdata_d     = rd_sh_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            GAP: begin
                if (tmr_q == 16'(CSN_GAP - 1)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        if (sample_en) begin
            rd_sh_d = {rd_sh_q[DATA_BITS-2:0], sample_bit};
        end
    end

    assign csn_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    assign ready_d = (state_d == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rd_sh_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            csn_q       <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rd_sh_q     <= rd_sh_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            csn_q       <= csn_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != IDLE);
    assign csn_o     = csn_q;
    assign mosi_o    = shift_q[FRAME_BITS-1];
    assign state_o   = state_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: pin-level monitor, mode-0 slave model and per-scenario tests.
module tb_spi_cmd_master;
    import spi_pkg::*;

    localparam int CLK_DIV   = 2;
    localparam int CSN_SETUP = 5;
    localparam int CSN_HOLD  = 5;
    localparam int CSN_GAP   = 4;
    localparam int FRAME_LOW = 1 + CSN_SETUP + 48 * CLK_DIV + CSN_HOLD;
    localparam int SCLK_PER  = 2 * CLK_DIV * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_opcode = 8'h00;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       sclk_o;
    logic       csn_o;
    logic       mosi_o;
    logic       miso_i = 1'b0;
    spi_state_e state_o;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_cmd_master #(
        .CLK_DIV  (CLK_DIV),
        .CSN_SETUP(CSN_SETUP),
        .CSN_HOLD (CSN_HOLD),
        .CSN_GAP  (CSN_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk_o    (sclk_o),
        .csn_o     (csn_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso_i),
        .state_o   (state_o)
    );

    // Mode-0 slave: after the 16th..23rd falling edge it presents slv_byte MSB first,
    // and drives random noise on every other falling edge.
    logic [7:0] slv_byte = 8'h00;
    int         slv_cnt = 0;
    logic       slv_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (csn_o) begin
            slv_cnt = 0;
        end else if (slv_prev && !sclk_o) begin
            slv_cnt++;
            if (slv_cnt >= 16 && slv_cnt <= 23) miso_i = slv_byte[23 - slv_cnt];
            else miso_i = 1'($urandom);
        end
        slv_prev = sclk_o;
    end

    // Pin monitor: one record per csn low window.
    typedef struct {
        logic [23:0] bits;
        int          rises;
        int          low_len;
        int          min_per;
        int          max_per;
        logic        first_mosi;
        int          gap_before;
    } frame_rec_t;

    frame_rec_t mon_frames[$];
    logic [7:0] mon_rsp_q[$];
    frame_rec_t cur;
    int         cur_edges = 0;
    int         rsp_long = 0;
    int         sclk_idle_hi = 0;
    int         high_cnt = 1000;
    longint     last_rise_t = 0;
    logic       prev_csn = 1'b1;
    logic       prev_sclk = 1'b0;
    logic       prev_rsp = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!csn_o) begin
            if (prev_csn) begin
                cur = '{default: 0};
                cur.min_per = 32'h3fff_ffff;
                cur.first_mosi = mosi_o;
                cur.gap_before = high_cnt;
                last_rise_t = 0;
                cur_edges = 0;
            end
            cur.low_len++;
            if (sclk_o && !prev_sclk) begin
                cur.rises++;
                cur.bits = {cur.bits[22:0], mosi_o};
                cur_edges++;
                if (last_rise_t != 0) begin
                    if (int'($time - last_rise_t) < cur.min_per) cur.min_per = int'($time - last_rise_t);
                    if (int'($time - last_rise_t) > cur.max_per) cur.max_per = int'($time - last_rise_t);
                end
                last_rise_t = longint'($time);
            end
            if (!sclk_o && prev_sclk) cur_edges++;
        end else begin
            if (!prev_csn) begin
                mon_frames.push_back(cur);
                high_cnt = 0;
            end
            high_cnt++;
            if (sclk_o) sclk_idle_hi++;
        end
        if (rsp_valid) begin
            mon_rsp_q.push_back(rsp_rdata);
            if (prev_rsp) rsp_long++;
        end
        prev_csn  = csn_o;
        prev_sclk = sclk_o;
        prev_rsp  = rsp_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] wd);
        int waited = 0;
        @(negedge clk);
        cmd_opcode = op;
        cmd_addr   = addr;
        cmd_wdata  = wd;
        cmd_valid  = 1'b1;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_opcode = 8'($urandom);
        cmd_addr   = 8'($urandom);
        cmd_wdata  = 8'($urandom);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int waited = 0;
        while (mon_frames.size() < target && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (mon_frames.size() < target) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d frames, want %0d", mon_frames.size(), target);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        n_cmp += 8;
        if (csn_o !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b want 1", csn_o); end
        if (sclk_o !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk_o); end
        if (mosi_o !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi_o); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (state_o !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", cmd_ready); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        int n0 = mon_frames.size();
        int r0 = mon_rsp_q.size();
        logic [23:0] exp_bits = {OP_WR, 8'h01, 8'h00};
        frame_rec_t rec;
        slv_byte = 8'($urandom);
        issue_cmd(OP_WR, 8'h01, 8'h00);
        wait_frames(n0 + 1, 400);
        idle(2);
        if (mon_frames.size() > n0) begin
            rec = mon_frames[n0];
            n_cmp += 7;
            if (rec.bits !== exp_bits) begin n_fail++; $display("FAIL wr_mosi: got %h want %h", rec.bits, exp_bits); end
            if (rec.rises != 24) begin n_fail++; $display("FAIL wr_rises: got %0d want 24", rec.rises); end
            if (rec.low_len != FRAME_LOW) begin n_fail++; $display("FAIL wr_csn_low: got %0d want %0d", rec.low_len, FRAME_LOW); end
            if (rec.min_per != SCLK_PER) begin n_fail++; $display("FAIL wr_per_min: got %0d want %0d", rec.min_per, SCLK_PER); end
            if (rec.max_per != SCLK_PER) begin n_fail++; $display("FAIL wr_per_max: got %0d want %0d", rec.max_per, SCLK_PER); end
            if (rec.first_mosi !== exp_bits[23]) begin n_fail++; $display("FAIL wr_first_mosi: got %b want %b", rec.first_mosi, exp_bits[23]); end
            if (mon_rsp_q.size() != r0 + 1) begin n_fail++; $display("FAIL wr_rsp_count: got %0d want %0d", mon_rsp_q.size() - r0, 1); end
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 6; i++) begin
            int n0 = mon_frames.size();
            int r0 = mon_rsp_q.size();
            logic [7:0] op = 8'($urandom);
            logic [7:0] ad = 8'($urandom);
            logic [7:0] wd = 8'($urandom);
            logic [7:0] exp_rd;
            slv_byte = (i == 0) ? 8'hA5 : 8'($urandom);
            exp_rd = slv_byte;
            issue_cmd(op, ad, wd);
            wait_frames(n0 + 1, 400);
            idle($urandom_range(2, 20));
            n_cmp += 4;
            if (mon_rsp_q.size() != r0 + 1) begin
                n_fail++; $display("FAIL rd_rsp_count[%0d]: got %0d want 1", i, mon_rsp_q.size() - r0);
            end else if (mon_rsp_q[r0] !== exp_rd) begin
                n_fail++; $display("FAIL rd_rdata[%0d]: got %h want %h", i, mon_rsp_q[r0], exp_rd);
            end
            if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL rd_hold[%0d]: got %h want %h", i, rsp_rdata, exp_rd); end
            if (mon_frames.size() > n0 && mon_frames[n0].bits !== {op, ad, wd}) begin
                n_fail++; $display("FAIL rd_mosi[%0d]: got %h want %h", i, mon_frames[n0].bits, {op, ad, wd});
            end
            if (rsp_long != 0) begin n_fail++; $display("FAIL rd_pulse_width[%0d]: got %0d long pulses want 0", i, rsp_long); end
        end
    endtask

    task automatic test_back_to_back();
        int n0 = mon_frames.size();
        int r0 = mon_rsp_q.size();
        int waited = 0;
        logic [23:0] fa = 24'($urandom);
        logic [23:0] fb = 24'($urandom);
        slv_byte = 8'($urandom);
        @(negedge clk);
        {cmd_opcode, cmd_addr, cmd_wdata} = fa;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 500) begin @(negedge clk); waited++; end
        @(posedge clk);
        @(negedge clk);
        {cmd_opcode, cmd_addr, cmd_wdata} = fb;
        waited = 0;
        while (!cmd_ready && waited < 500) begin @(negedge clk); waited++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_frames(n0 + 2, 500);
        idle(3);
        n_cmp += 5;
        if (mon_frames.size() >= n0 + 2) begin
            if (mon_frames[n0].bits !== fa) begin n_fail++; $display("FAIL b2b_frame_a: got %h want %h", mon_frames[n0].bits, fa); end
            if (mon_frames[n0+1].bits !== fb) begin n_fail++; $display("FAIL b2b_frame_b: got %h want %h", mon_frames[n0+1].bits, fb); end
            if (mon_frames[n0+1].gap_before != CSN_GAP + 1) begin
                n_fail++; $display("FAIL b2b_gap: got %0d want %0d", mon_frames[n0+1].gap_before, CSN_GAP + 1);
            end
        end
        if (mon_rsp_q.size() != r0 + 2) begin
            n_fail++; $display("FAIL b2b_rsp_count: got %0d want 2", mon_rsp_q.size() - r0);
        end else if (mon_rsp_q[r0] !== slv_byte || mon_rsp_q[r0+1] !== slv_byte) begin
            n_fail++; $display("FAIL b2b_rdata: got %h/%h want %h", mon_rsp_q[r0], mon_rsp_q[r0+1], slv_byte);
        end
        if (rsp_long != 0) begin n_fail++; $display("FAIL b2b_pulse_width: got %0d long pulses want 0", rsp_long); end
    endtask

    task automatic test_busy_drop();
        int n0 = mon_frames.size();
        int waited = 0;
        logic [23:0] f = 24'($urandom);
        issue_cmd(f[23:16], f[15:8], f[7:0]);
        while (cur.rises < 4 && waited < 200) begin @(negedge clk); waited++; end
        @(negedge clk);
        cmd_opcode = ~f[23:16];
        cmd_addr   = ~f[15:8];
        cmd_wdata  = ~f[7:0];
        cmd_valid  = 1'b1;
        n_cmp += 2;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", cmd_ready); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy: got %b want 1", busy); end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_frames(n0 + 1, 400);
        idle(60);
        n_cmp += 3;
        if (mon_frames.size() != n0 + 1) begin n_fail++; $display("FAIL drop_frame_count: got %0d want 1", mon_frames.size() - n0); end
        if (mon_frames.size() > n0 && mon_frames[n0].bits !== f) begin
            n_fail++; $display("FAIL drop_frame_bits: got %h want %h", mon_frames[n0].bits, f);
        end
        if (mon_frames.size() > n0 && mon_frames[n0].rises != 24) begin
            n_fail++; $display("FAIL drop_rises: got %0d want 24", mon_frames[n0].rises);
        end
    endtask

    task automatic test_reset_mid();
        int r0 = mon_rsp_q.size();
        int n1;
        int waited = 0;
        logic [23:0] f = 24'($urandom);
        logic [23:0] g = 24'($urandom);
        slv_byte = 8'($urandom);
        issue_cmd(f[23:16], f[15:8], f[7:0]);
        while (cur_edges < 10 && waited < 200) begin @(negedge clk); waited++; end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp += 4;
        if (csn_o !== 1'b1) begin n_fail++; $display("FAIL abort_csn: got %b want 1", csn_o); end
        if (sclk_o !== 1'b0) begin n_fail++; $display("FAIL abort_sclk: got %b want 0", sclk_o); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_valid: got %b want 0", rsp_valid); end
        idle(3);
        rst = 1'b0;
        idle(150);
        n_cmp += 2;
        if (mon_rsp_q.size() != r0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d pulses want 0", mon_rsp_q.size() - r0); end
        if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL abort_rdata: got %h want 00", rsp_rdata); end
        n1 = mon_frames.size();
        issue_cmd(g[23:16], g[15:8], g[7:0]);
        wait_frames(n1 + 1, 400);
        idle(3);
        n_cmp += 3;
        if (mon_frames.size() > n1) begin
            if (mon_frames[n1].bits !== g) begin n_fail++; $display("FAIL post_abort_bits: got %h want %h", mon_frames[n1].bits, g); end
            if (mon_frames[n1].low_len != FRAME_LOW) begin
                n_fail++; $display("FAIL post_abort_low: got %0d want %0d", mon_frames[n1].low_len, FRAME_LOW);
            end
        end
        if (mon_rsp_q.size() != r0 + 1 || rsp_rdata !== slv_byte) begin
            n_fail++; $display("FAIL post_abort_rsp: got %0d pulses data %h want 1 pulse data %h", mon_rsp_q.size() - r0, rsp_rdata, slv_byte);
        end
    endtask

    initial begin
        test_reset();
        idle(3);
        test_write();
        test_read();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid();
        n_cmp++;
        if (sclk_idle_hi != 0) begin n_fail++; $display("FAIL sclk_idle: sclk high for %0d csn-high cycles, want 0", sclk_idle_hi); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
